// File: rtl/hub75_fb_writein.sv
// ---------------------------------------------------------------------------
// hub75_fb_writein
//
// Purpose:
//   Takes a raster pixel stream and writes it into the current line buffer
//   one pixel per accepted beat. When a line is complete, the block asks the
//   framebuffer to store that line. When the last line of the frame is
//   stored, it requests a display/back buffer swap.
//   The line order is y = 0 .. N_BANKS*N_ROWS-1, with bank = y / N_ROWS and
//   row = y mod N_ROWS.
//
// Ports:
//   clk, rst          - clock; asynchronous active-high reset
//   in_data           - pixel word, N_CHANS*N_PLANES bits
//   in_sof            - first pixel of frame marker
//   in_valid/in_ready - pixel handshake
//   fb_wr_data        - line-buffer write data (in_data passthrough)
//   fb_wr_col_addr    - line-buffer column of the write
//   fb_wr_en          - line-buffer write strobe (same cycle as acceptance)
//   fb_wr_bank_addr   - bank of the line being stored
//   fb_wr_row_addr    - row of the line being stored
//   fb_wr_row_store   - one-cycle store request
//   fb_wr_row_swap    - one-cycle line-buffer half swap (with the store)
//   fb_wr_row_rdy     - framebuffer idle, a store may be issued
//   fb_frame_swap     - one-cycle display/back buffer swap
//   frame_done        - one-cycle pulse, identical to fb_frame_swap
//   err_resync        - one-cycle pulse when an SOF forces a resync
//
// Handshake:
//   A pixel transfers on every rising edge where in_valid & in_ready are
//   both 1. in_valid may rise or fall on any cycle. in_data and in_sof are
//   only looked at while in_valid is 1. in_ready is a registered signal and
//   is 1 only in FILL. The line-buffer write (fb_wr_en/data/col_addr) is
//   combinational from the handshake, so it appears in the cycle of the
//   transfer.
//
// Configuration:
//   HUB75_FBW_SOF_RESYNC_EN - if defined, an accepted pixel with in_sof=1
//   that is not at (line 0, col 0) restarts the frame. The pixel goes to
//   col 0, the partial frame is dropped, and err_resync pulses. If the macro
//   is not defined, in_sof is ignored and err_resync stays 0.
// ---------------------------------------------------------------------------
module hub75_fb_writein #(
    parameter int N_BANKS  = 2,
    parameter int N_ROWS   = 32,
    parameter int N_COLS   = 64,
    parameter int N_CHANS  = 3,
    parameter int N_PLANES = 8,
    localparam int DW = N_CHANS * N_PLANES,
    localparam int CW = (N_COLS  > 1) ? $clog2(N_COLS)  : 1,
    localparam int BW = (N_BANKS > 1) ? $clog2(N_BANKS) : 1,
    localparam int RW = (N_ROWS  > 1) ? $clog2(N_ROWS)  : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_sof,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] fb_wr_data,
    output logic [CW-1:0] fb_wr_col_addr,
    output logic          fb_wr_en,
    output logic [BW-1:0] fb_wr_bank_addr,
    output logic [RW-1:0] fb_wr_row_addr,
    output logic          fb_wr_row_store,
    output logic          fb_wr_row_swap,
    input  logic          fb_wr_row_rdy,
    output logic          fb_frame_swap,
    output logic          frame_done,
    output logic          err_resync
);

    typedef enum logic [2:0] {
        S_FILL  = 3'd0,
        S_WAIT  = 3'd1,
        S_STORE = 3'd2,
        S_FLUSH = 3'd3,
        S_SWAP  = 3'd4
    } state_t;

    localparam logic [CW-1:0] COL_LAST  = CW'(N_COLS - 1);
    localparam logic [CW-1:0] COL_ONE   = CW'(1);
    localparam logic [BW-1:0] BANK_LAST = BW'(N_BANKS - 1);
    localparam logic [BW-1:0] BANK_ONE  = BW'(1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(N_ROWS - 1);
    localparam logic [RW-1:0] ROW_ONE   = RW'(1);

    state_t        state;
    logic [CW-1:0] col;
    logic [BW-1:0] bank;
    logic [RW-1:0] row;
    // Set on entry to FLUSH. fb_wr_row_rdy may still show the idle level
    // from before the final store was seen, so the first FLUSH cycle does
    // not trust it.
    logic          flush_first;

    logic accept;
    logic resync;
    logic last_line;

    assign accept    = in_valid & in_ready;
    assign last_line = (bank == BANK_LAST) && (row == ROW_LAST);

`ifdef HUB75_FBW_SOF_RESYNC_EN
    // An SOF anywhere except the true frame start restarts the frame.
    assign resync = accept & in_sof & ((col != '0) | (bank != '0) | (row != '0));
`else
    logic unused_in_sof;
    assign unused_in_sof = in_sof;
    assign resync        = 1'b0;
`endif

    // Line-buffer write path: combinational, in the acceptance cycle.
    assign fb_wr_en        = accept;
    assign fb_wr_data      = in_data;
    assign fb_wr_col_addr  = resync ? '0 : col;
    // The line counter only moves when STORE ends, so these addresses stay
    // on the completed line for the whole store cycle.
    assign fb_wr_bank_addr = bank;
    assign fb_wr_row_addr  = row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_FILL;
            col             <= '0;
            bank            <= '0;
            row             <= '0;
            flush_first     <= 1'b0;
            in_ready        <= 1'b1;
            fb_wr_row_store <= 1'b0;
            fb_wr_row_swap  <= 1'b0;
            fb_frame_swap   <= 1'b0;
            frame_done      <= 1'b0;
            err_resync      <= 1'b0;
        end else begin
            // Pulse outputs are low unless the transition below sets them.
            fb_wr_row_store <= 1'b0;
            fb_wr_row_swap  <= 1'b0;
            fb_frame_swap   <= 1'b0;
            frame_done      <= 1'b0;
            err_resync      <= 1'b0;

            case (state)
                S_FILL: begin
                    if (resync) begin
                        // The SOF pixel has already been written at col 0.
                        col        <= COL_ONE;
                        bank       <= '0;
                        row        <= '0;
                        err_resync <= 1'b1;
                    end else if (accept) begin
                        if (col == COL_LAST) begin
                            col      <= '0;
                            state    <= S_WAIT;
                            in_ready <= 1'b0;
                        end else begin
                            col <= col + COL_ONE;
                        end
                    end
                end

                S_WAIT: begin
                    if (fb_wr_row_rdy) begin
                        state           <= S_STORE;
                        fb_wr_row_store <= 1'b1;
                        fb_wr_row_swap  <= 1'b1;
                    end
                end

                S_STORE: begin
                    if (last_line) begin
                        bank        <= '0;
                        row         <= '0;
                        state       <= S_FLUSH;
                        flush_first <= 1'b1;
                    end else begin
                        if (row == ROW_LAST) begin
                            row  <= '0;
                            bank <= bank + BANK_ONE;
                        end else begin
                            row <= row + ROW_ONE;
                        end
                        state    <= S_FILL;
                        in_ready <= 1'b1;
                    end
                end

                S_FLUSH: begin
                    flush_first <= 1'b0;
                    if (!flush_first && fb_wr_row_rdy) begin
                        state         <= S_SWAP;
                        fb_frame_swap <= 1'b1;
                        frame_done    <= 1'b1;
                    end
                end

                S_SWAP: begin
                    state    <= S_FILL;
                    in_ready <= 1'b1;
                end

                default: begin
                    state    <= S_FILL;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_fb_writein.sv
// ---------------------------------------------------------------------------
// tb_hub75_fb_writein
//
// Purpose:
//   Self-checking bench for hub75_fb_writein.
//   A reference model works out the expected line-buffer writes, line stores
//   and frame swaps from the raster rules. It uses pixel and line counts and
//   queues. A small framebuffer model drives fb_wr_row_rdy.
//
// Ports:
//   none (top-level bench)
//
// Configuration:
//   HUB75_FBW_SOF_RESYNC_EN - if defined, the model applies the SOF resync
//   rule.
// ---------------------------------------------------------------------------
module tb_hub75_fb_writein;

    localparam int N_BANKS  = 2;
    localparam int N_ROWS   = 32;
    localparam int N_COLS   = 64;
    localparam int N_CHANS  = 3;
    localparam int N_PLANES = 8;
    localparam int DW    = N_CHANS * N_PLANES;
    localparam int CW    = $clog2(N_COLS);
    localparam int BW    = $clog2(N_BANKS);
    localparam int RW    = $clog2(N_ROWS);
    localparam int TOTAL = N_BANKS * N_ROWS;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_sof;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] fb_wr_data;
    logic [CW-1:0] fb_wr_col_addr;
    logic          fb_wr_en;
    logic [BW-1:0] fb_wr_bank_addr;
    logic [RW-1:0] fb_wr_row_addr;
    logic          fb_wr_row_store;
    logic          fb_wr_row_swap;
    logic          fb_wr_row_rdy;
    logic          fb_frame_swap;
    logic          frame_done;
    logic          err_resync;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    hub75_fb_writein #(
        .N_BANKS(N_BANKS), .N_ROWS(N_ROWS), .N_COLS(N_COLS),
        .N_CHANS(N_CHANS), .N_PLANES(N_PLANES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_sof(in_sof),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .fb_wr_data(fb_wr_data),
        .fb_wr_col_addr(fb_wr_col_addr),
        .fb_wr_en(fb_wr_en),
        .fb_wr_bank_addr(fb_wr_bank_addr),
        .fb_wr_row_addr(fb_wr_row_addr),
        .fb_wr_row_store(fb_wr_row_store),
        .fb_wr_row_swap(fb_wr_row_swap),
        .fb_wr_row_rdy(fb_wr_row_rdy),
        .fb_frame_swap(fb_frame_swap),
        .frame_done(frame_done),
        .err_resync(err_resync)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [DW+CW-1:0] exp_q[$];      // expected writes {data, col}
    logic [BW+RW-1:0] st_q[$];       // expected stores {bank, row}
    int m_col = 0;
    int m_line = 0;
    int m_frames = 0;
    int swaps_pending = 0;
    int resync_pending = 0;
    int exp_resync_total = 0;
    int got_frames = 0;
    int got_resync = 0;
    int sof_seen = 0;

    task automatic model_accept(input logic [DW-1:0] d, input bit sof);
        bit rs;
        rs = 1'b0;
        if (sof) sof_seen++;
`ifdef HUB75_FBW_SOF_RESYNC_EN
        if (sof && (m_line != 0 || m_col != 0)) rs = 1'b1;
`endif
        if (rs) begin
            exp_q.push_back({d, CW'(0)});
            m_col = 1;
            m_line = 0;
            resync_pending++;
            exp_resync_total++;
        end else begin
            exp_q.push_back({d, CW'(m_col)});
            m_col++;
            if (m_col == N_COLS) begin
                m_col = 0;
                st_q.push_back({BW'(m_line / N_ROWS), RW'(m_line % N_ROWS)});
                if (m_line == TOTAL - 1) begin
                    m_line = 0;
                    m_frames++;
                    swaps_pending++;
                end else begin
                    m_line++;
                end
            end
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        st_q.delete();
        m_col = 0;
        m_line = 0;
        swaps_pending = 0;
        resync_pending = 0;
    endtask

    // ---------------- framebuffer model ----------------
    // rdy drops one cycle after a store is seen, for a random time in busy
    // mode. hold_low keeps it low on request.
    bit hold_low = 1'b0;
    bit busy_mode = 1'b0;
    int busy_cnt = 0;
    bit st_seen = 1'b0;
    bit st_delay = 1'b0;

    initial begin
        fb_wr_row_rdy = 1'b1;
        forever begin
            @(negedge clk);
            st_seen = fb_wr_row_store;
            @(posedge clk);
            #1;
            if (busy_cnt > 0) busy_cnt--;
            if (st_delay) busy_cnt = busy_mode ? $urandom_range(90, 1) : 0;
            st_delay = st_seen;
            fb_wr_row_rdy = !hold_low && (busy_cnt == 0);
        end
    end

    // ---------------- monitor ----------------
    bit strict = 1'b1;               // rdy held 1: exact latencies apply
    int last_acc = 0;
    int last_store = 0;
    int ready_check_at = -1;
    bit prev_rdy = 1'b1;

    initial begin
        logic [DW+CW-1:0] e;
        logic [BW+RW-1:0] s;
        forever begin
            @(negedge clk);
            if (cyc > 95000) begin
                check("watchdog", 32'(cyc), 32'd95000);
                $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
                $finish;
            end
            if (!rst) begin
                if (fb_wr_en) begin
                    if (exp_q.size() == 0) begin
                        check("wr_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_data", 32'(fb_wr_data), 32'(e[DW+CW-1:CW]));
                        check("wr_col", 32'(fb_wr_col_addr), 32'(e[CW-1:0]));
                    end
                    if (fb_wr_col_addr == CW'(N_COLS - 1)) last_acc = cyc;
                end
                if (ready_check_at == cyc) check("ready_after_store", 32'(in_ready), 1);
                if (fb_wr_row_store) begin
                    check("row_swap_with_store", 32'(fb_wr_row_swap), 1);
                    check("store_needs_rdy", 32'(prev_rdy), 1);
                    if (strict) check("store_latency", 32'(cyc - last_acc), 2);
                    else check("store_latency_min", 32'((cyc - last_acc) >= 2), 1);
                    if (st_q.size() == 0) begin
                        check("store_unexpected", 1, 0);
                    end else begin
                        s = st_q.pop_front();
                        check("store_bank", 32'(fb_wr_bank_addr), 32'(s[BW+RW-1:RW]));
                        check("store_row", 32'(fb_wr_row_addr), 32'(s[RW-1:0]));
                        if (strict && s != {BW'(N_BANKS - 1), RW'(N_ROWS - 1)})
                            ready_check_at = cyc + 1;
                    end
                    last_store = cyc;
                end else if (fb_wr_row_swap) begin
                    check("row_swap_alone", 32'(fb_wr_row_swap), 0);
                end
                if (fb_frame_swap || frame_done) begin
                    check("frame_done_eq_swap", 32'(frame_done), 32'(fb_frame_swap));
                    check("swap_expected", 32'(swaps_pending > 0), 1);
                    if (swaps_pending > 0) swaps_pending--;
                    check("swap_needs_rdy", 32'(prev_rdy), 1);
                    if (strict) check("swap_latency", 32'(cyc - last_store), 3);
                    else check("swap_latency_min", 32'((cyc - last_store) >= 3), 1);
                    got_frames++;
                end
                if (err_resync) begin
                    check("resync_expected", 32'(resync_pending > 0), 1);
                    if (resync_pending > 0) resync_pending--;
                    got_resync++;
                end
                prev_rdy = fb_wr_row_rdy;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Entry and exit are both 1 time unit after a rising edge.
    task automatic send_pixel(input logic [DW-1:0] d, input bit sof, input int gap_pct);
        bit acc;
        int bound;
        while ($urandom_range(99, 0) < gap_pct) begin
            in_valid = 1'b0;
            in_data  = DW'($urandom);
            in_sof   = 1'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        model_accept(d, sof);
        bound = 0;
        acc = 1'b0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            bound++;
            if (!acc && bound > 2000) begin
                check("accept_timeout", 0, 1);
                acc = 1'b1;
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int gap_pct, input int sof_at);
        int target;
        int k;
        target = m_frames + 1;
        k = 0;
        while (m_frames < target) begin
            send_pixel(DW'($urandom), (k == 0) || (k == sof_at), gap_pct);
            k++;
        end
    endtask

    task automatic wait_swaps();
        int b;
        b = 0;
        while (swaps_pending > 0 && b < 400) begin
            @(posedge clk);
            b++;
        end
        #1;
        check("swap_timeout", 32'(swaps_pending), 0);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_store", 32'(fb_wr_row_store), 0);
        check("rst_row_swap", 32'(fb_wr_row_swap), 0);
        check("rst_frame_swap", 32'(fb_frame_swap), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_err_resync", 32'(err_resync), 0);
        check("rst_wr_en", 32'(fb_wr_en), 0);
        model_reset();
        ready_check_at = -1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_sof = 1'b0;
        #3;
        check("init_in_ready", 32'(in_ready), 1);
        check("init_store", 32'(fb_wr_row_store), 0);
        check("init_frame_swap", 32'(fb_frame_swap), 0);
        check("init_frame_done", 32'(frame_done), 0);
        check("init_err_resync", 32'(err_resync), 0);
        check("init_wr_en", 32'(fb_wr_en), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back frame with rdy held high: exact latencies.
        strict = 1'b1;
        send_frame(0, -1);
        wait_swaps();
        check("frames_after_first", 32'(got_frames), 1);

        // Row 0 stalls on rdy=0 for 10 cycles.
        strict = 1'b0;
        @(negedge clk);
        hold_low = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < N_COLS; i++) send_pixel(DW'($urandom), i == 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 0);
            check("stall_no_store", 32'(fb_wr_row_store), 0);
        end
        hold_low = 1'b0;
        @(negedge clk);
        check("rdy_rise_store_pre", 32'(fb_wr_row_store), 0);
        @(negedge clk);
        check("rdy_rise_store", 32'(fb_wr_row_store), 1);
        // Rest of that frame: 50% input gaps with a busy framebuffer.
        busy_mode = 1'b1;
        @(posedge clk);
        #1;
        while (m_frames < 2) send_pixel(DW'($urandom), 1'b0, 50);
        wait_swaps();
        busy_mode = 1'b0;
        repeat (100) @(posedge clk);
        #1;

        // Reset mid-row, then reset while a store is pending.
        strict = 1'b1;
        for (int i = 0; i < 100; i++) send_pixel(DW'($urandom), i == 0, 0);
        do_reset();
        @(negedge clk);
        hold_low = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < N_COLS; i++) send_pixel(DW'($urandom), i == 0, 0);
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        hold_low = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        send_frame(0, -1);
        wait_swaps();

        // SOF on pixel 70, then a full frame with random gaps.
        send_frame(0, 70);
        wait_swaps();
        send_frame(50, -1);
        wait_swaps();
        repeat (10) @(posedge clk);
        #1;

        check("end_wr_queue", 32'(exp_q.size()), 0);
        check("end_store_queue", 32'(st_q.size()), 0);
        check("end_resync_pending", 32'(resync_pending), 0);
        check("end_frames", 32'(got_frames), 32'(m_frames));
        check("end_resync_count", 32'(got_resync), 32'(exp_resync_total));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
